// File: rtl/tone_arbiter.sv
// N-channel piezo tone generator with fixed-priority arbitration (channel 0 wins).
// One shared tone counter drives a registered output; period/duty latch only at wave boundaries.
module tone_arbiter #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PERIOD_W = 20,
    parameter int unsigned DUR_W    = 24,
    parameter int unsigned IDX_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_trig,
    input  logic [NUM_CH*PERIOD_W-1:0] ch_period,
    input  logic [NUM_CH*3-1:0]        ch_shift,
    input  logic [NUM_CH*DUR_W-1:0]    ch_dur,
    output logic                       piezo_out,
    output logic                       active_valid,
    output logic [IDX_W-1:0]           active_ch,
    output logic [NUM_CH-1:0]          busy
);

    localparam int unsigned FULL_W = PERIOD_W + 1;

    logic [DUR_W-1:0]    r_cnt [NUM_CH];
    logic [DUR_W-1:0]    w_cnt_d [NUM_CH];
    logic                w_win_valid;
    logic [IDX_W-1:0]    w_win_idx;
    logic [PERIOD_W-1:0] w_win_period;
    logic [2:0]          w_win_shift;
    logic [2:0]          w_shamt;
    logic [FULL_W-1:0]   w_new_full;
    logic [FULL_W-1:0]   w_new_thr;
    logic [FULL_W-1:0]   w_tone_inc;
    logic [FULL_W-1:0]   r_tone_cnt;
    logic [FULL_W-1:0]   r_lat_full;
    logic [FULL_W-1:0]   r_lat_thr;
    logic                w_takeover;
    logic                w_relatch;

    // One-shot counters: a trigger with nonzero duration reloads, else count down to zero.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_cnt_d[i] = r_cnt[i];
            busy[i]    = (r_cnt[i] != '0);
            if (ch_trig[i] && (ch_dur[i*DUR_W +: DUR_W] != '0)) begin
                w_cnt_d[i] = ch_dur[i*DUR_W +: DUR_W];
            end else if (r_cnt[i] != '0) begin
                w_cnt_d[i] = r_cnt[i] - DUR_W'(1);
            end
        end
    end

    // Descending scan so the lowest-index active channel is the final assignment.
    always_comb begin
        w_win_valid  = 1'b0;
        w_win_idx    = '0;
        w_win_period = '0;
        w_win_shift  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req[i] || busy[i]) begin
                w_win_valid  = 1'b1;
                w_win_idx    = IDX_W'(i);
                w_win_period = ch_period[i*PERIOD_W +: PERIOD_W];
                w_win_shift  = ch_shift[i*3 +: 3];
            end
        end
    end

    always_comb begin
        w_shamt    = (w_win_shift == 3'd0) ? 3'd1 : w_win_shift;
        w_new_full = {w_win_period, 1'b0};
        w_new_thr  = w_new_full >> w_shamt;
        if ((w_new_full != '0) && (w_new_thr == '0)) begin
            w_new_thr = FULL_W'(1);
        end
        w_tone_inc = r_tone_cnt + FULL_W'(1);
        w_takeover = !active_valid || (w_win_idx != active_ch);
        // Takeover, resting owner and end-of-period all restart the wave from fresh inputs.
        w_relatch  = w_takeover || (r_lat_full == '0) ||
                     (r_tone_cnt == (r_lat_full - FULL_W'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
            piezo_out    <= 1'b0;
            active_valid <= 1'b0;
            active_ch    <= '0;
            r_tone_cnt   <= '0;
            r_lat_full   <= '0;
            r_lat_thr    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
            if (!w_win_valid) begin
                active_valid <= 1'b0;
                r_tone_cnt   <= '0;
                piezo_out    <= 1'b0;
            end else if (w_relatch) begin
                active_ch    <= w_win_idx;
                active_valid <= 1'b1;
                r_tone_cnt   <= '0;
                r_lat_full   <= w_new_full;
                r_lat_thr    <= w_new_thr;
                piezo_out    <= (w_win_period != '0);
            end else begin
                r_tone_cnt <= w_tone_inc;
                piezo_out  <= (w_tone_inc < r_lat_thr);
            end
        end
    end

endmodule

// File: tb/tb_tone_arbiter.sv
// Bench for tone_arbiter: vector table, directed multi-cycle sequences and a randomized run
// checked against an integer-level reference model of the arbitration and waveform rules.
module tb_tone_arbiter;

    localparam int NCH = 4;
    localparam int PW  = 20;
    localparam int DW  = 24;
    localparam int IW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    trig = '0;
    logic [NCH*PW-1:0] period = '0;
    logic [NCH*3-1:0]  shift = '0;
    logic [NCH*DW-1:0] dur = '0;
    logic              piezo_out;
    logic              active_valid;
    logic [IW-1:0]     active_ch;
    logic [NCH-1:0]    busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state in plain integers.
    int m_rem [NCH];
    bit m_valid;
    int m_own;
    int m_pos;
    int m_full;
    int m_thr;
    bit m_pz;

    typedef struct {
        logic [NCH-1:0] req;
        logic [NCH-1:0] trig;
        logic           pz;
        logic           valid;
        logic [IW-1:0]  ch;
        logic [NCH-1:0] busy;
    } vec_t;

    vec_t tbl [10];

    tone_arbiter #(
        .NUM_CH  (NCH),
        .PERIOD_W(PW),
        .DUR_W   (DW),
        .IDX_W   (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_req      (req),
        .ch_trig     (trig),
        .ch_period   (period),
        .ch_shift    (shift),
        .ch_dur      (dur),
        .piezo_out   (piezo_out),
        .active_valid(active_valid),
        .active_ch   (active_ch),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary want completion");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int per_of(input int i);
        return int'(period[i*PW +: PW]);
    endfunction

    function automatic int sh_of(input int i);
        return int'(shift[i*3 +: 3]);
    endfunction

    function automatic int dur_of(input int i);
        return int'(dur[i*DW +: DW]);
    endfunction

    function automatic logic [NCH-1:0] m_busy();
        logic [NCH-1:0] b;
        for (int i = 0; i < NCH; i++) b[i] = (m_rem[i] != 0);
        return b;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) m_rem[i] = 0;
        m_valid = 0;
        m_own   = 0;
        m_pos   = 0;
        m_full  = 0;
        m_thr   = 0;
        m_pz    = 0;
    endfunction

    function automatic void model_edge();
        int win;
        int p;
        int sh;
        int nrem [NCH];
        win = -1;
        for (int i = 0; i < NCH; i++) begin
            if (win < 0 && (req[i] || m_rem[i] != 0)) win = i;
        end
        for (int i = 0; i < NCH; i++) begin
            if (trig[i] && dur_of(i) != 0) nrem[i] = dur_of(i);
            else nrem[i] = (m_rem[i] > 0) ? m_rem[i] - 1 : 0;
        end
        if (win < 0) begin
            m_valid = 0;
            m_pos   = 0;
            m_pz    = 0;
        end else if (!m_valid || win != m_own || m_full == 0 || m_pos == m_full - 1) begin
            p       = per_of(win);
            sh      = (sh_of(win) == 0) ? 1 : sh_of(win);
            m_own   = win;
            m_valid = 1;
            m_pos   = 0;
            m_full  = 2 * p;
            m_thr   = m_full / (1 << sh);
            if (m_full != 0 && m_thr == 0) m_thr = 1;
            m_pz    = (p != 0);
        end else begin
            m_pos = m_pos + 1;
            m_pz  = (m_pos < m_thr);
        end
        m_rem = nrem;
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        chk("model_pz", 32'(piezo_out), 32'(m_pz));
        chk("model_valid", 32'(active_valid), 32'(m_valid));
        chk("model_ch", 32'(active_ch), 32'(m_own));
        chk("model_busy", 32'(busy), 32'(m_busy()));
    endtask

    task automatic set_ch(input int i, input int per, input int sh, input int du);
        period[i*PW +: PW] = PW'(per);
        shift[i*3 +: 3]    = 3'(sh);
        dur[i*DW +: DW]    = DW'(du);
    endtask

    task automatic do_reset();
        req  = '0;
        trig = '0;
        rst  = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int nb;
        int nown;
        int nhi;
        logic e;

        model_reset();
        for (int k = 0; k < 10; k++) begin
            tbl[k].req   = 4'b0100;
            tbl[k].trig  = 4'b0000;
            tbl[k].valid = 1'b1;
            tbl[k].ch    = 2'd2;
            tbl[k].busy  = 4'b0000;
            tbl[k].pz    = (k < 4) || (k >= 8);
        end

        // Reset state.
        do_reset();
        chk("reset_pz", 32'(piezo_out), 0);
        chk("reset_valid", 32'(active_valid), 0);
        chk("reset_ch", 32'(active_ch), 0);
        chk("reset_busy", 32'(busy), 0);

        // Table: channel 2, period 4, shift 1 -> 4 high / 4 low.
        set_ch(2, 4, 1, 0);
        for (int k = 0; k < 10; k++) begin
            req  = tbl[k].req;
            trig = tbl[k].trig;
            step();
            chk("tbl_pz", 32'(piezo_out), 32'(tbl[k].pz));
            chk("tbl_valid", 32'(active_valid), 32'(tbl[k].valid));
            chk("tbl_ch", 32'(active_ch), 32'(tbl[k].ch));
            chk("tbl_busy", 32'(busy), 32'(tbl[k].busy));
        end

        // One-shot on channel 0 preempts channel 3, which then restarts.
        do_reset();
        set_ch(2, 0, 0, 0);
        set_ch(3, 3, 1, 0);
        req = 4'b1000;
        repeat (5) step();
        set_ch(0, 2, 2, 20);
        trig = 4'b0001;
        step();
        trig = '0;
        nb   = busy[0] ? 1 : 0;
        nown = 0;
        nhi  = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (busy[0]) nb++;
            if (active_valid && active_ch == 2'd0) begin
                nown++;
                if (piezo_out) nhi++;
            end
            if (k == 21) begin
                chk("preempt_resume_ch", 32'(active_ch), 3);
                chk("preempt_resume_pz", 32'(piezo_out), 1);
            end
        end
        chk("preempt_busy_cycles", nb, 20);
        chk("preempt_own_cycles", nown, 20);
        chk("preempt_high_cycles", nhi, 5);

        // Period change mid high-phase waits for the wrap.
        do_reset();
        set_ch(0, 0, 0, 0);
        set_ch(3, 0, 0, 0);
        set_ch(1, 4, 1, 0);
        req = 4'b0010;
        for (int k = 1; k <= 21; k++) begin
            step();
            if (k == 2) set_ch(1, 6, 1, 0);
            if (k <= 8) e = (k <= 4);
            else if (k <= 20) e = ((k - 9) < 6);
            else e = 1'b1;
            chk("perchg_pz", 32'(piezo_out), 32'(e));
        end

        // Rest on channel 0 silences channel 1; release restores it next cycle.
        do_reset();
        set_ch(1, 4, 1, 0);
        set_ch(0, 0, 1, 0);
        req = 4'b0010;
        repeat (3) step();
        req = 4'b0011;
        step();
        chk("rest_ch", 32'(active_ch), 0);
        chk("rest_valid", 32'(active_valid), 1);
        chk("rest_pz", 32'(piezo_out), 0);
        repeat (3) begin
            step();
            chk("rest_hold_pz", 32'(piezo_out), 0);
        end
        req = 4'b0010;
        step();
        chk("unrest_ch", 32'(active_ch), 1);
        chk("unrest_pz", 32'(piezo_out), 1);

        // Retrigger extends busy with no gap: 5 + 10 cycles.
        do_reset();
        set_ch(1, 5, 1, 10);
        trig = 4'b0010;
        step();
        trig = '0;
        nb = busy[1] ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) trig = 4'b0010;
            step();
            trig = '0;
            if (busy[1]) nb++;
        end
        chk("retrig_busy_cycles", nb, 15);

        // Trigger with zero duration is ignored, idle or running.
        do_reset();
        set_ch(1, 5, 1, 0);
        trig = 4'b0010;
        step();
        trig = '0;
        step();
        chk("dur0_idle_busy", 32'(busy), 0);
        set_ch(1, 5, 1, 5);
        trig = 4'b0010;
        step();
        nb = busy[1] ? 1 : 0;
        set_ch(1, 5, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            if (k > 2) trig = '0;
            step();
            if (busy[1]) nb++;
        end
        trig = '0;
        chk("dur0_running_busy_cycles", nb, 5);

        // Asynchronous reset mid-tone with two channels busy.
        do_reset();
        set_ch(0, 3, 1, 50);
        set_ch(2, 5, 1, 50);
        trig = 4'b0101;
        step();
        trig = '0;
        repeat (6) step();
        chk("prerst_busy", 32'(busy), 32'h5);
        chk("prerst_valid", 32'(active_valid), 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_pz", 32'(piezo_out), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_valid", 32'(active_valid), 0);
        step();
        step();
        rst = 1'b0;
        repeat (5) begin
            step();
            chk("postrst_pz", 32'(piezo_out), 0);
            chk("postrst_valid", 32'(active_valid), 0);
        end

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            set_ch(i, int'($urandom_range(6)), int'($urandom_range(7)), int'($urandom_range(30)));
        end
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(31) == 0) begin
                    set_ch(i, int'($urandom_range(6)), int'($urandom_range(7)),
                           int'($urandom_range(30)));
                end
                req[i]  = ($urandom_range(3) == 0);
                trig[i] = ($urandom_range(15) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
